// File: rtl/calc_add_arb_pkg.sv
// Shared constants for the calc adder arbiter: kernel data width and slot FSM encodings.
package calc_add_arb_pkg;

    localparam int CALC_DATA_WD = 16;

    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_INFL = 2'd1;
    localparam logic [1:0] SLOT_DONE = 2'd2;

endpackage

// File: rtl/calc_add_arb_if.sv
// Requester-side bus of the calc adder arbiter: request handshake, operands and per-requester response slots.
interface calc_add_arb_if #(
    parameter int REQ_NUM = 4,
    parameter int DATA_WD = 16
);
    logic [REQ_NUM-1:0]         req_val_i;
    logic [REQ_NUM-1:0]         req_rdy_o;
    logic [REQ_NUM*DATA_WD-1:0] req_dat_a_i;
    logic [REQ_NUM*DATA_WD-1:0] req_dat_b_i;
    logic [REQ_NUM-1:0]         req_flg_sat_i;
    logic [REQ_NUM-1:0]         rsp_val_o;
    logic [REQ_NUM-1:0]         rsp_rdy_i;
    logic [REQ_NUM*DATA_WD-1:0] rsp_dat_o;

    modport slave (
        input  req_val_i, req_dat_a_i, req_dat_b_i, req_flg_sat_i, rsp_rdy_i,
        output req_rdy_o, rsp_val_o, rsp_dat_o
    );

    modport master (
        output req_val_i, req_dat_a_i, req_dat_b_i, req_flg_sat_i, rsp_rdy_i,
        input  req_rdy_o, rsp_val_o, rsp_dat_o
    );
endinterface

// File: rtl/calc_add_arb_rr.sv
// Generic round-robin arbiter: searches upward from the pointer with wrap; pointer moves past each winner.
module calc_arb_rr #(
    parameter int REQ_NUM = 4,
    localparam int IDX_WD = $clog2(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] i_req,
    output logic [REQ_NUM-1:0] o_gnt,
    output logic [IDX_WD-1:0]  o_gnt_idx,
    output logic               o_gnt_vld
);

    logic [IDX_WD-1:0] r_ptr;
    logic [IDX_WD-1:0] w_cand;
    logic [IDX_WD-1:0] w_ptr_nxt;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_cand    = '0;
        for (int off = 0; off < REQ_NUM; off++) begin
            w_cand = IDX_WD'((int'(r_ptr) + off) % REQ_NUM);
            if (!o_gnt_vld && i_req[w_cand]) begin
                o_gnt_vld     = 1'b1;
                o_gnt_idx     = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (o_gnt_idx == IDX_WD'(REQ_NUM - 1)) ? '0 : o_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_ptr <= '0;
        else if (o_gnt_vld) r_ptr <= w_ptr_nxt;
    end

endmodule

// File: rtl/calc_add_knl.sv
// Single-cycle 16-bit signed adder kernel with optional saturation; result valid one cycle after val_i.
module calc_add_knl
    import calc_add_arb_pkg::*;
(
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           val_i,
    input  logic signed [CALC_DATA_WD-1:0] dat_a_i,
    input  logic signed [CALC_DATA_WD-1:0] dat_b_i,
    input  logic                           sat_i,
    output logic                           val_o,
    output logic signed [CALC_DATA_WD-1:0] dat_o
);

    function automatic logic signed [CALC_DATA_WD-1:0] sat_add(
        input logic signed [CALC_DATA_WD-1:0] a,
        input logic signed [CALC_DATA_WD-1:0] b,
        input logic                           sat
    );
        logic signed [CALC_DATA_WD:0] sum;
        sum = {a[CALC_DATA_WD-1], a} + {b[CALC_DATA_WD-1], b};
        // Overflow shows up as disagreement between the two top bits of the 17-bit sum.
        if (sat && (sum[CALC_DATA_WD] != sum[CALC_DATA_WD-1]))
            return sum[CALC_DATA_WD] ? {1'b1, {(CALC_DATA_WD-1){1'b0}}}
                                     : {1'b0, {(CALC_DATA_WD-1){1'b1}}};
        return sum[CALC_DATA_WD-1:0];
    endfunction

    logic                           r_vld_p1;
    logic signed [CALC_DATA_WD-1:0] r_dat_p1;

    // ---- stage p0 -> p1 ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_vld_p1 <= 1'b0;
        else       r_vld_p1 <= val_i;
    end

    always_ff @(posedge clk) begin
        r_dat_p1 <= sat_add(dat_a_i, dat_b_i, sat_i);
    end

    assign val_o = r_vld_p1;
    assign dat_o = r_dat_p1;

endmodule

// File: rtl/calc_add_arb.sv
// Shares one calc_add_knl among REQ_NUM requesters: round-robin issue, tag tracking, registered response slots.
module calc_add_arb
    import calc_add_arb_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int DATA_WD = CALC_DATA_WD,
    localparam int IDX_WD = $clog2(REQ_NUM)
) (
    input  logic           clk,
    input  logic           rst,
    calc_add_arb_if.slave  bus
);

    logic [1:0]                 r_slot [REQ_NUM];
    logic [REQ_NUM*DATA_WD-1:0] r_rsp_dat;
    logic [REQ_NUM-1:0]         w_elig;
    logic [REQ_NUM-1:0]         w_gnt;
    logic [IDX_WD-1:0]          w_gnt_idx;
    logic                       w_gnt_vld;

    // A slot that just left DONE reads IDLE only from the next cycle, so there is no bypass.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < REQ_NUM; i++)
            w_elig[i] = bus.req_val_i[i] & (r_slot[i] == SLOT_IDLE) & ~rst;
    end

    calc_arb_rr #(.REQ_NUM(REQ_NUM)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_elig),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign bus.req_rdy_o = w_gnt;

    // ---- stage p0: operand mux from the granted requester ----
    logic signed [DATA_WD-1:0] w_a_p0;
    logic signed [DATA_WD-1:0] w_b_p0;
    logic                      w_sat_p0;

    assign w_a_p0   = $signed(bus.req_dat_a_i[w_gnt_idx*DATA_WD +: DATA_WD]);
    assign w_b_p0   = $signed(bus.req_dat_b_i[w_gnt_idx*DATA_WD +: DATA_WD]);
    assign w_sat_p0 = bus.req_flg_sat_i[w_gnt_idx];

    logic                      w_knl_vld_p1;
    logic signed [DATA_WD-1:0] w_knl_dat_p1;

    calc_add_knl u_knl (
        .clk     (clk),
        .rstn    (~rst),
        .val_i   (w_gnt_vld),
        .dat_a_i (w_a_p0),
        .dat_b_i (w_b_p0),
        .sat_i   (w_sat_p0),
        .val_o   (w_knl_vld_p1),
        .dat_o   (w_knl_dat_p1)
    );

    // ---- stage p1: owner tag travels alongside the kernel result ----
    logic              r_tag_vld_p1;
    logic [IDX_WD-1:0] r_tag_idx_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld_p1 <= 1'b0;
            r_tag_idx_p1 <= '0;
        end else begin
            r_tag_vld_p1 <= w_gnt_vld;
            r_tag_idx_p1 <= w_gnt_idx;
        end
    end

    logic [REQ_NUM-1:0] w_land_p1;

    always_comb begin
        w_land_p1 = '0;
        for (int i = 0; i < REQ_NUM; i++)
            w_land_p1[i] = w_knl_vld_p1 & r_tag_vld_p1 & (r_tag_idx_p1 == IDX_WD'(i));
    end

    // ---- stage p2: per-requester response slots ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_dat <= '0;
            for (int i = 0; i < REQ_NUM; i++) r_slot[i] <= SLOT_IDLE;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                case (r_slot[i])
                    SLOT_IDLE: if (w_gnt[i]) r_slot[i] <= SLOT_INFL;
                    SLOT_INFL: if (w_land_p1[i]) begin
                        r_slot[i]                          <= SLOT_DONE;
                        r_rsp_dat[i*DATA_WD +: DATA_WD] <= w_knl_dat_p1;
                    end
                    SLOT_DONE: if (bus.rsp_rdy_i[i]) r_slot[i] <= SLOT_IDLE;
                    default:   r_slot[i] <= SLOT_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.rsp_val_o = '0;
        for (int i = 0; i < REQ_NUM; i++)
            bus.rsp_val_o[i] = (r_slot[i] == SLOT_DONE);
    end

    assign bus.rsp_dat_o = r_rsp_dat;

endmodule

// File: tb/tb_calc_add_arb.sv
// Randomized and directed bench for calc_add_arb against a transaction-level reference model.
module tb_calc_add_arb;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk;
    logic rst;

    calc_add_arb_if #(.REQ_NUM(N), .DATA_WD(DW)) bus ();

    calc_add_arb #(.REQ_NUM(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding request per requester, its result and the cycle it becomes visible.
    bit          m_busy  [N];
    logic [15:0] m_dat   [N];
    int          m_avail [N];
    int          m_ptr;
    int          m_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic sat);
        int sa, sb, s;
        sa = int'(a); if (sa > 32767) sa -= 65536;
        sb = int'(b); if (sb > 32767) sb -= 65536;
        s  = sa + sb;
        if (sat) begin
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
        end
        return s[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_ptr = 0;
    endtask

    // Called just after a negedge with inputs already driven; leaves at the next negedge.
    task automatic step();
        logic [N-1:0] exp_gnt;
        bit           acc [N];
        bit           ev;
        int           k;
        #1;
        exp_gnt = '0;
        k = -1;
        for (int off = 0; off < N; off++) begin
            int c;
            c = (m_ptr + off) % N;
            if (k < 0 && bus.req_val_i[c] && !m_busy[c]) k = c;
        end
        if (k >= 0) exp_gnt[k] = 1'b1;
        check("grant", bus.req_rdy_o, exp_gnt);
        for (int i = 0; i < N; i++) begin
            ev = m_busy[i] && (m_cyc >= m_avail[i]);
            check($sformatf("rsp_val%0d", i), bus.rsp_val_o[i], ev);
            if (ev) check($sformatf("rsp_dat%0d", i), bus.rsp_dat_o[i*DW +: DW], m_dat[i]);
            acc[i] = ev && bus.rsp_rdy_i[i];
        end
        if (k >= 0) begin
            m_dat[k]   = ref_add(bus.req_dat_a_i[k*DW +: DW], bus.req_dat_b_i[k*DW +: DW],
                                 bus.req_flg_sat_i[k]);
            m_avail[k] = m_cyc + 2;
            m_ptr      = (k + 1) % N;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) if (acc[i]) m_busy[i] = 1'b0;
        if (k >= 0) m_busy[k] = 1'b1;
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sat);
        bus.req_dat_a_i[idx*DW +: DW] = a;
        bus.req_dat_b_i[idx*DW +: DW] = b;
        bus.req_flg_sat_i[idx]        = sat;
    endtask

    task automatic single(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic sat, input logic [15:0] exp, input string tag);
        bus.req_val_i      = '0;
        bus.req_val_i[idx] = 1'b1;
        set_op(idx, a, b, sat);
        step();
        bus.req_val_i = '0;
        step();
        #1;
        check({tag, "_val"}, bus.rsp_val_o[idx], 1'b1);
        check({tag, "_dat"}, bus.rsp_dat_o[idx*DW +: DW], exp);
        step();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            logic [15:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            set_op(i, a, b, 1'($urandom));
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_val_i     = '0;
        bus.req_dat_a_i   = '0;
        bus.req_dat_b_i   = '0;
        bus.req_flg_sat_i = '0;
        bus.rsp_rdy_i     = '1;
        model_reset();
        m_cyc = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_rdy", bus.req_rdy_o, '0);
        bus.req_val_i = '1;
        #1;
        check("reset_rdy_req", bus.req_rdy_o, '0);
        check("reset_val", bus.rsp_val_o, '0);
        check("reset_dat", bus.rsp_dat_o, '0);
        bus.req_val_i = '0;
        @(negedge clk);
        rst = 1'b0;

        // Basic add, then saturation/wrap corners
        single(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, "add0");
        single(1, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, "satpos");
        single(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, "wrap");
        single(1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, "satneg");

        // All requesting: one grant per cycle, rotating
        bus.req_val_i = '1;
        bus.rsp_rdy_i = '1;
        for (int c = 0; c < 12; c++) begin
            rand_ops();
            step();
        end

        // Backpressure on requester 1
        bus.rsp_rdy_i = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            rand_ops();
            #1;
            if (m_busy[1]) check("bp_rdy1", bus.req_rdy_o[1], 1'b0);
            step();
        end
        bus.rsp_rdy_i = '1;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            step();
        end
        bus.req_val_i = '0;
        for (int c = 0; c < 4; c++) step();

        // Pointer after a grant to 2: 3 wins over 0
        bus.req_val_i = 4'b0100;
        step();
        bus.req_val_i = '0;
        step();
        step();
        bus.req_val_i = 4'b1001;
        #1;
        check("rr_after2", bus.req_rdy_o, 4'b1000);
        step();
        #1;
        check("rr_then0", bus.req_rdy_o, 4'b0001);
        step();
        bus.req_val_i = '0;
        for (int c = 0; c < 4; c++) step();

        // Reset the cycle after a handshake
        bus.req_val_i = 4'b0100;
        step();
        bus.req_val_i = '0;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", bus.req_rdy_o, '0);
        check("mid_rst_val", bus.rsp_val_o, '0);
        check("mid_rst_dat", bus.rsp_dat_o, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_val_i = 4'b1001;
        #1;
        check("post_rst_gnt", bus.req_rdy_o, 4'b0001);
        step();
        bus.req_val_i = '0;
        for (int c = 0; c < 5; c++) step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.req_val_i = 4'($urandom);
            bus.rsp_rdy_i = 4'($urandom) | 4'($urandom);
            rand_ops();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
